// File: rtl/audio_pkg.sv
// Shared timing and sample-format constants for the audio output path.
package audio_pkg;

    localparam int unsigned CLOCKS_PER_SAMPLE = 2500;
    localparam int unsigned SAMPLE_W          = 12;

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/audio_pwm_dac_counter.sv
// pwm_period_counter: free-running period counter for the PWM DAC.
// Parks at zero while disabled; boundary marks the last clock of each period.
module pwm_period_counter #(
    parameter int unsigned PERIOD = audio_pkg::CLOCKS_PER_SAMPLE,
    parameter int unsigned CNT_W  = audio_pkg::SAMPLE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             boundary
);

    import audio_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);

    logic at_max;

    assign at_max   = (cnt == CNT_MAX);
    assign boundary = en && at_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || at_max) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/audio_pwm_dac.sv
// audio_pwm_dac: one-sample-deep buffered PWM DAC driving the speaker pins.
// Optional DAC_UNDERFLOW_CNT_EN adds a saturating underflow_count output.
module audio_pwm_dac #(
    parameter int unsigned CYCLES_PER_SAMPLE = audio_pkg::CLOCKS_PER_SAMPLE,
    parameter int unsigned SAMPLE_W          = audio_pkg::SAMPLE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_data,
    output logic                sample_tick,
    output logic                underflow,
    output logic                aud_pwm,
    output logic                aud_sd
`ifdef DAC_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]         underflow_count
`endif
);

    import audio_pkg::*;

    localparam logic [SAMPLE_W-1:0] MAX_CODE = SAMPLE_W'(CYCLES_PER_SAMPLE);

    logic [SAMPLE_W-1:0] cnt;
    logic                boundary;
    logic [SAMPLE_W-1:0] shadow;
    logic                shadow_full;
    logic [SAMPLE_W-1:0] active_duty;
    logic [SAMPLE_W-1:0] code_sat;
    logic                xfer;

    pwm_period_counter #(
        .PERIOD (CYCLES_PER_SAMPLE),
        .CNT_W  (SAMPLE_W)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .cnt      (cnt),
        .boundary (boundary)
    );

    assign s_ready  = !shadow_full;
    assign xfer     = s_valid && s_ready;
    assign code_sat = (s_data > MAX_CODE) ? MAX_CODE : s_data;

    // A transfer can only land when the shadow is empty, so it never races the
    // boundary hand-off below; an arrival on the boundary waits a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            shadow_full <= 1'b0;
            active_duty <= '0;
        end else begin
            if (boundary && shadow_full) begin
                active_duty <= shadow;
                shadow_full <= 1'b0;
            end
            if (xfer) begin
                shadow      <= code_sat;
                shadow_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_tick <= 1'b0;
            underflow   <= 1'b0;
            aud_pwm     <= 1'b0;
            aud_sd      <= 1'b0;
        end else begin
            sample_tick <= boundary;
            underflow   <= boundary && !shadow_full;
            aud_pwm     <= en && (cnt < active_duty);
            aud_sd      <= en;
        end
    end

`ifdef DAC_UNDERFLOW_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_count <= '0;
        end else if (underflow && (underflow_count != '1)) begin
            underflow_count <= underflow_count + 16'd1;
        end
    end
`endif

endmodule
